// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator front-panel sequencer.
package calc_pkg;

  localparam int OPERAND_W = 8;

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    CAPTURE = 3'd4,
    SHOW    = 3'd5
  } state_e;

  // Result multiplexer order in the datapath
  localparam logic [1:0] UNIT_0 = 2'd0;
  localparam logic [1:0] UNIT_1 = 2'd1;
  localparam logic [1:0] UNIT_2 = 2'd2;
  localparam logic [1:0] UNIT_3 = 2'd3;

  function automatic logic is_busy(input state_e st);
    return (st == EXEC) || (st == CAPTURE);
  endfunction

endpackage

// File: rtl/calc_sequencer_button_debouncer.sv
// Synchronizes one active-low key, debounces it and emits a one-cycle press pulse.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic btn_n,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;
  logic             press_q;

  // Level is accepted only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      if (sync2_q != level_q) begin
        if (cnt_q == CNT_MAX) begin
          level_q <= sync2_q;
          cnt_q   <= '0;
          press_q <= ~sync2_q;
        end else begin
          cnt_q   <= cnt_q + CNT_W'(1);
          press_q <= 1'b0;
        end
      end else begin
        cnt_q   <= '0;
        press_q <= 1'b0;
      end
    end
  end

  assign press = press_q;

endmodule

// File: rtl/calc_sequencer.sv
// Front-panel sequencer: operand entry, timed datapath drive, result capture and chaining.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SETTLE_CYCLES   = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [1:0]           buttons,
  input  logic [9:0]           switches,
  input  logic [OPERAND_W-1:0] dp_result,
  input  logic                 dp_carry,
  output logic [OPERAND_W-1:0] dp_a,
  output logic [OPERAND_W-1:0] dp_b,
  output logic [1:0]           dp_op,
  output logic [1:0]           dp_unit,
  output logic [OPERAND_W-1:0] result,
  output logic                 carry,
  output logic                 result_valid,
  output logic [2:0]           phase,
  output logic                 busy
);

  localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int SW = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_EFF - 1);

  logic enter_press_s;
  logic clear_press_s;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clock   (clock),
    .reset_n (reset_n),
    .btn_n   (buttons[0]),
    .press   (enter_press_s)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clock   (clock),
    .reset_n (reset_n),
    .btn_n   (buttons[1]),
    .press   (clear_press_s)
  );

  state_e               state_q, state_d;
  logic [OPERAND_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [1:0]           op_q, op_d, unit_q, unit_d;
  logic                 carry_q, carry_d, valid_q, valid_d, busy_q, busy_d;
  logic [SW-1:0]        cnt_q, cnt_d;

  // Next-state logic; clear overrides everything, including an in-flight EXEC
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    unit_d  = unit_q;
    res_d   = res_q;
    carry_d = carry_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (clear_press_s) begin
      state_d = LOAD_A;
      a_d     = '0;
      b_d     = '0;
      op_d    = 2'd0;
      unit_d  = 2'd0;
      res_d   = '0;
      carry_d = 1'b0;
      valid_d = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        LOAD_A: begin
          if (enter_press_s) begin
            a_d     = switches[OPERAND_W-1:0];
            state_d = LOAD_B;
          end else begin
            state_d = LOAD_A;
          end
        end
        LOAD_B: begin
          if (enter_press_s) begin
            b_d     = switches[OPERAND_W-1:0];
            state_d = LOAD_OP;
          end else begin
            state_d = LOAD_B;
          end
        end
        LOAD_OP: begin
          if (enter_press_s) begin
            op_d    = switches[9:8];
            unit_d  = switches[1:0];
            cnt_d   = SETTLE_LOAD;
            state_d = EXEC;
          end else begin
            state_d = LOAD_OP;
          end
        end
        EXEC: begin
          if (cnt_q == '0) begin
            state_d = CAPTURE;
          end else begin
            cnt_d = cnt_q - SW'(1);
          end
        end
        CAPTURE: begin
          res_d   = dp_result;
          carry_d = dp_carry;
          valid_d = 1'b1;
          state_d = SHOW;
        end
        SHOW: begin
          if (enter_press_s) begin
            a_d     = res_q;
            valid_d = 1'b0;
            cnt_d   = SETTLE_LOAD;
            state_d = EXEC;
          end else begin
            state_d = SHOW;
          end
        end
        default: state_d = LOAD_A;
      endcase
    end
    busy_d = is_busy(state_d);
  end

  // State and all outputs are registered together
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 2'd0;
      unit_q  <= 2'd0;
      res_q   <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      unit_q  <= unit_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dp_a         = a_q;
  assign dp_b         = b_q;
  assign dp_op        = op_q;
  assign dp_unit      = unit_q;
  assign result       = res_q;
  assign carry        = carry_q;
  assign result_valid = valid_q;
  assign phase        = state_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a queue of expected captures.
module tb_calc_sequencer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [1:0] buttons;
  logic [9:0] switches;
  logic [7:0] dp_result;
  logic       dp_carry;
  logic [7:0] dp_a, dp_b, result;
  logic [1:0] dp_op, dp_unit;
  logic       carry, result_valid, busy;
  logic [2:0] phase;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];

  calc_sequencer #(.DEBOUNCE_CYCLES(4), .SETTLE_CYCLES(2)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .buttons      (buttons),
    .switches     (switches),
    .dp_result    (dp_result),
    .dp_carry     (dp_carry),
    .dp_a         (dp_a),
    .dp_b         (dp_b),
    .dp_op        (dp_op),
    .dp_unit      (dp_unit),
    .result       (result),
    .carry        (carry),
    .result_valid (result_valid),
    .phase        (phase),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input int idx, input int low, input int high);
    buttons[idx] = 1'b0;
    repeat (low) @(negedge clock);
    buttons[idx] = 1'b1;
    repeat (high) @(negedge clock);
  endtask

  task automatic wait_phase(input logic [2:0] tgt, input int budget, input string tag);
    int n = 0;
    while (phase !== tgt && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk(tag, {29'd0, phase}, {29'd0, tgt});
  endtask

  // Called at the negedge of the first EXEC cycle
  task automatic exec_check(input logic [7:0] ea, input logic [7:0] eb,
                            input logic [1:0] eop, input logic [1:0] eunit);
    logic [8:0] e;
    chk("dp_a_E", {24'd0, dp_a}, {24'd0, ea});
    chk("dp_b_E", {24'd0, dp_b}, {24'd0, eb});
    chk("dp_op_E", {30'd0, dp_op}, {30'd0, eop});
    chk("dp_unit_E", {30'd0, dp_unit}, {30'd0, eunit});
    chk("busy_E", {31'd0, busy}, 32'd1);
    chk("rv_E", {31'd0, result_valid}, 32'd0);
    @(negedge clock);
    chk("phase_E1", {29'd0, phase}, 32'd3);
    chk("busy_E1", {31'd0, busy}, 32'd1);
    @(negedge clock);
    chk("phase_E2", {29'd0, phase}, 32'd4);
    chk("busy_E2", {31'd0, busy}, 32'd1);
    chk("rv_E2", {31'd0, result_valid}, 32'd0);
    chk("dp_a_E2", {24'd0, dp_a}, {24'd0, ea});
    @(negedge clock);
    chk("phase_E3", {29'd0, phase}, 32'd5);
    chk("busy_E3", {31'd0, busy}, 32'd0);
    chk("rv_E3", {31'd0, result_valid}, 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("result_E3", {24'd0, result}, {24'd0, e[7:0]});
      chk("carry_E3", {31'd0, carry}, {31'd0, e[8]});
    end else begin
      chk("exp_queue_nonempty", 32'd0, 32'd1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int busy_cnt;
    logic rv_seen;
    reset_n = 1'b0;
    buttons = 2'b11;
    switches = 10'd0;
    dp_result = 8'h00;
    dp_carry = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_phase", {29'd0, phase}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;

    // 1: idle after reset, no spurious press
    repeat (10) @(negedge clock);
    chk("idle_phase", {29'd0, phase}, 32'd0);
    chk("idle_outs", {5'd0, dp_a, dp_b, result, carry, result_valid, dp_op, dp_unit, busy},
        32'd0);

    // 2: full entry and first execution
    switches = 10'h023;
    press(0, 8, 8);
    chk("loadA_phase", {29'd0, phase}, 32'd1);
    chk("loadA_dp_a", {24'd0, dp_a}, 32'h23);
    switches = 10'h005;
    press(0, 8, 8);
    chk("loadB_phase", {29'd0, phase}, 32'd2);
    chk("loadB_dp_b", {24'd0, dp_b}, 32'h05);
    switches = 10'b01_0000_0010;
    dp_result = 8'h28;
    dp_carry = 1'b0;
    exp_q.push_back({1'b0, 8'h28});
    buttons[0] = 1'b0;
    wait_phase(3'd3, 20, "exec1_entry");
    exec_check(8'h23, 8'h05, 2'd1, 2'd2);
    buttons[0] = 1'b1;
    repeat (10) @(negedge clock);
    chk("show_hold_phase", {29'd0, phase}, 32'd5);
    chk("show_hold_rv", {31'd0, result_valid}, 32'd1);

    // 3: chaining result into A
    dp_result = 8'h2D;
    dp_carry = 1'b1;
    exp_q.push_back({1'b1, 8'h2D});
    buttons[0] = 1'b0;
    wait_phase(3'd3, 20, "exec2_entry");
    exec_check(8'h28, 8'h05, 2'd1, 2'd2);
    buttons[0] = 1'b1;
    repeat (10) @(negedge clock);

    // 4: clear, then bounces shorter than the debounce window
    press(1, 8, 8);
    chk("clear_phase", {29'd0, phase}, 32'd0);
    chk("clear_regs", {5'd0, dp_a, dp_b, result, carry, result_valid, dp_op, dp_unit, busy},
        32'd0);
    switches = 10'h05A;
    for (int i = 0; i < 5; i++) press(0, 3, 3);
    repeat (6) @(negedge clock);
    chk("bounce_phase", {29'd0, phase}, 32'd0);
    chk("bounce_dp_a", {24'd0, dp_a}, 32'd0);
    press(0, 6, 10);
    chk("held_phase", {29'd0, phase}, 32'd1);
    chk("held_dp_a", {24'd0, dp_a}, 32'h5A);

    // 5a: clear lands in the first EXEC cycle
    switches = 10'h011;
    press(0, 8, 8);
    chk("abort_setup_phase", {29'd0, phase}, 32'd2);
    switches = 10'b10_0000_0011;
    dp_result = 8'hEE;
    buttons[0] = 1'b0;
    @(negedge clock);
    buttons[1] = 1'b0;
    busy_cnt = 0;
    rv_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (i == 8) buttons = 2'b11;
      busy_cnt += int'(busy);
      rv_seen |= result_valid;
    end
    chk("abort_busy_cycles", busy_cnt, 32'd1);
    chk("abort_rv_seen", {31'd0, rv_seen}, 32'd0);
    chk("abort_phase", {29'd0, phase}, 32'd0);
    chk("abort_regs", {5'd0, dp_a, dp_b, result, carry, result_valid, dp_op, dp_unit, busy},
        32'd0);

    // 5b: clear and enter pulses in the same cycle
    switches = 10'h033;
    press(0, 8, 8);
    chk("both_setup_phase", {29'd0, phase}, 32'd1);
    buttons = 2'b00;
    repeat (8) @(negedge clock);
    buttons = 2'b11;
    repeat (8) @(negedge clock);
    chk("both_phase", {29'd0, phase}, 32'd0);
    chk("both_dp_a", {24'd0, dp_a}, 32'd0);

    // 6: asynchronous reset during EXEC
    switches = 10'h012;
    press(0, 8, 8);
    switches = 10'h034;
    press(0, 8, 8);
    switches = 10'b11_0000_0001;
    buttons[0] = 1'b0;
    wait_phase(3'd3, 20, "exec3_entry");
    reset_n = 1'b0;
    #1;
    chk("async_rst_phase", {29'd0, phase}, 32'd0);
    chk("async_rst_regs", {5'd0, dp_a, dp_b, result, carry, result_valid, dp_op, dp_unit, busy},
        32'd0);
    buttons = 2'b11;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
    chk("post_rst_phase", {29'd0, phase}, 32'd0);
    chk("exp_queue_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
